// File: rtl/sl_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sl_tx_scheduler
// Purpose  : Shares one serial-line word transmitter between NREQ requesters.
//            Round-robin grant, latch of the granted word/length, start/done
//            handshake with the transmitter, per-word timeout supervision and
//            a forced idle gap between words on the line.
// Ports    : clk        - core clock (16 MHz)
//            rst_n      - synchronous active-low reset
//            enable     - 1 = new grants allowed
//            req        - per-requester word pending (held until ack/err)
//            req_data   - packed 32-bit words, requester i at [32*i+:32]
//            req_len    - packed 6-bit bit counts, requester i at [6*i+:6]
//            ack / err  - 1-cycle one-hot completion / rejection pulses
//            tx_start   - 1-cycle start pulse to the transmitter
//            tx_data    - latched word, stable from tx_start to tx_done
//            tx_len     - latched bit count, stable likewise
//            tx_busy    - transmitter busy
//            tx_done    - 1-cycle transmitter finished pulse
//            active_id  - index of current/last granted requester
//            busy       - scheduler not idle
// Revision : 1.0 - initial release
// ============================================================================
module sl_tx_scheduler #(
  parameter int NREQ       = 4,
  parameter int GAP_CYCLES = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*32-1:0] req_data,
  input  logic [NREQ*6-1:0] req_len,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   err,
  output logic              tx_start,
  output logic [31:0]       tx_data,
  output logic [5:0]        tx_len,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic [1:0]        active_id,
  output logic              busy
);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_arb   = 3'd1;
  localparam logic [2:0] c_start = 3'd2;
  localparam logic [2:0] c_wait  = 3'd3;
  localparam logic [2:0] c_gap   = 3'd4;

  // A word finishing (ack or err) goes to the gap state, or straight back
  // to idle when no gap is configured.
  localparam logic [2:0] c_post = (GAP_CYCLES == 0) ? c_idle : c_gap;

  localparam int c_tw = $clog2(TIMEOUT + 1);
  localparam int c_gw = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [c_tw-1:0] c_to_last  = c_tw'(TIMEOUT - 1);
  localparam logic [c_gw-1:0] c_gap_last = c_gw'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [2:0]      r_state;
  logic [1:0]      r_last;
  logic [1:0]      r_active;
  logic [c_tw-1:0] r_tcnt;
  logic [c_gw-1:0] r_gcnt;
  logic [NREQ-1:0] r_ack;
  logic [NREQ-1:0] r_err;
  logic [31:0]     r_data;
  logic [5:0]      r_len;

  logic            w_found;
  logic [1:0]      w_grant;
  logic [NREQ-1:0] w_grant_oh;
  logic [31:0]     w_data;
  logic [5:0]      w_len;
  logic            w_len_ok;
  logic [NREQ-1:0] w_active_oh;
  logic [c_tw-1:0] w_tcnt_inc;

  // Round-robin search: offsets 1..NREQ from the last grant, first pending
  // requester wins. Inner loop keeps every vector index a constant.
  always_comb begin
    w_found    = 1'b0;
    w_grant    = 2'd0;
    w_grant_oh = '0;
    w_data     = 32'd0;
    w_len      = 6'd0;
    for (int i = 1; i <= NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!w_found && req[j] && (j == ((int'(r_last) + i) % NREQ))) begin
          w_found       = 1'b1;
          w_grant       = 2'(j);
          w_grant_oh[j] = 1'b1;
          w_data        = req_data[32*j +: 32];
          w_len         = req_len[6*j +: 6];
        end
      end
    end
  end

  assign w_len_ok = (w_len >= 6'd8) && (w_len <= 6'd32);

  always_comb begin
    w_active_oh = '0;
    for (int j = 0; j < NREQ; j++) begin
      w_active_oh[j] = (r_active == 2'(j));
    end
  end

  // Counter is cleared when tx_start fires; the incremented value equals the
  // number of cycles since tx_start, so the abort decision lands on the
  // cycle TIMEOUT-1 after tx_start and err shows TIMEOUT cycles after it.
  assign w_tcnt_inc = r_tcnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= c_idle;
      r_last   <= 2'(NREQ - 1);
      r_active <= 2'd0;
      r_tcnt   <= '0;
      r_gcnt   <= '0;
      r_ack    <= '0;
      r_err    <= '0;
      r_data   <= 32'd0;
      r_len    <= 6'd0;
    end else begin
      r_ack <= '0;
      r_err <= '0;
      case (r_state)
        c_idle: begin
          if (enable && (|req)) r_state <= c_arb;
        end
        c_arb: begin
          if (!w_found) begin
            r_state <= c_idle;
          end else begin
            r_data   <= w_data;
            r_len    <= w_len;
            r_active <= w_grant;
            r_last   <= w_grant;
            if (w_len_ok) begin
              r_state <= c_start;
            end else begin
              r_err   <= w_grant_oh;
              r_gcnt  <= '0;
              r_state <= c_post;
            end
          end
        end
        c_start: begin
          if (!tx_busy) begin
            r_tcnt  <= '0;
            r_state <= c_wait;
          end
        end
        c_wait: begin
          r_tcnt <= w_tcnt_inc;
          // tx_done has priority over a coincident timeout.
          if (tx_done) begin
            r_ack   <= w_active_oh;
            r_gcnt  <= '0;
            r_state <= c_post;
          end else if (w_tcnt_inc == c_to_last) begin
            r_err   <= w_active_oh;
            r_gcnt  <= '0;
            r_state <= c_post;
          end
        end
        c_gap: begin
          if (r_gcnt == c_gap_last) r_state <= c_idle;
          else                      r_gcnt  <= r_gcnt + 1'b1;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  // Start pulse follows tx_busy within the cycle so a free transmitter is
  // started two cycles after the request is seen.
  assign tx_start  = (r_state == c_start) && !tx_busy;
  assign tx_data   = r_data;
  assign tx_len    = r_len;
  assign ack       = r_ack;
  assign err       = r_err;
  assign active_id = r_active;
  assign busy      = (r_state != c_idle);

endmodule
`default_nettype wire

// File: tb/tb_sl_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sl_tx_scheduler
// Purpose  : Self-checking bench for sl_tx_scheduler. Inputs are driven 1 ns
//            after the rising edge, outputs sampled on the falling edge.
//            Expected grants, timing and pulses come from a transaction-level
//            model of the scheduling rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sl_tx_scheduler;

  localparam int NREQ       = 4;
  localparam int GAP_CYCLES = 32;
  localparam int TIMEOUT    = 1024;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         enable   = 1'b0;
  logic [3:0]   req      = '0;
  logic [127:0] req_data = '0;
  logic [23:0]  req_len  = '0;
  logic [3:0]   ack;
  logic [3:0]   err;
  logic         tx_start;
  logic [31:0]  tx_data;
  logic [5:0]   tx_len;
  logic         tx_busy  = 1'b0;
  logic         tx_done  = 1'b0;
  logic [1:0]   active_id;
  logic         busy;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;
  int m_last   = NREQ - 1;   // model's last-grant pointer

  sl_tx_scheduler #(
    .NREQ       (NREQ),
    .GAP_CYCLES (GAP_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req       (req),
    .req_data  (req_data),
    .req_len   (req_len),
    .ack       (ack),
    .err       (err),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_len    (tx_len),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .active_id (active_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Round-robin rule: first pending index after the last grant, wrapping.
  function automatic int rr_pick(input logic [3:0] mask);
    for (int i = 1; i <= NREQ; i++) begin
      if (mask[(m_last + i) % NREQ]) return (m_last + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 2 * TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_before_word", busy, 0);
  endtask

  // One word: request mask, cycles the transmitter stays busy, cycles from
  // tx_start to tx_done (-1 = transmitter never answers).
  task automatic do_word(input logic [3:0] mask, input int bcyc, input int dly);
    int g, c, es, ep, n_start, n_pulse, s_cyc, p_cyc;
    logic [31:0] edata, s_data;
    logic [5:0]  elen, s_len;
    logic [1:0]  s_id;
    logic [3:0]  p_ack, p_err, oh;
    bit valid;
    wait_idle();
    @(posedge clk); #1;
    c       = cyc;
    enable  = 1'b1;
    req     = mask;
    tx_busy = (bcyc > 0);
    tx_done = 1'b0;
    g       = rr_pick(mask);
    m_last  = g;
    oh      = 4'(1 << g);
    edata   = req_data[32*g +: 32];
    elen    = req_len[6*g +: 6];
    valid   = (elen >= 6'd8) && (elen <= 6'd32);
    es      = (bcyc > 2) ? c + bcyc : c + 2;
    if (!valid)       ep = c + 2;
    else if (dly < 0) ep = es + TIMEOUT;
    else              ep = es + dly + 1;
    n_start = 0; n_pulse = 0; s_cyc = 0; p_cyc = 0;
    s_data = '0; s_len = '0; s_id = '0; p_ack = '0; p_err = '0;
    while (cyc <= ep + 1) begin
      @(negedge clk);
      if (tx_start) begin
        n_start++; s_cyc = cyc; s_data = tx_data; s_len = tx_len; s_id = active_id;
      end
      if (ack != 0 || err != 0) begin
        n_pulse++; p_cyc = cyc; p_ack = ack; p_err = err;
      end
      @(posedge clk); #1;
      if (cyc == c + bcyc) tx_busy = 1'b0;
      tx_done = valid && (dly > 0) && (cyc == es + dly);
      // Source words change once latched; the word in flight must not.
      if (cyc == c + 2) begin
        req_data = {$urandom, $urandom, $urandom, $urandom};
        req_len  = {4{6'($urandom)}};
      end
      if (n_pulse != 0) req = '0;
    end
    tx_done = 1'b0;
    tx_busy = 1'b0;
    req     = '0;
    if (valid) begin
      check_val("start_count", n_start, 1);
      check_val("start_cycle", s_cyc, es);
      check_val("tx_data", s_data, edata);
      check_val("tx_len", s_len, elen);
      check_val("active_id", s_id, g);
    end else begin
      check_val("badlen_no_start", n_start, 0);
    end
    check_val("pulse_count", n_pulse, 1);
    check_val("pulse_cycle", p_cyc, ep);
    check_val("ack_vec", p_ack, (valid && dly >= 0) ? oh : 4'd0);
    check_val("err_vec", p_err, (valid && dly >= 0) ? 4'd0 : oh);
    // Gap: GAP_CYCLES cycles busy starting with the pulse cycle, then idle.
    while (cyc < ep + GAP_CYCLES - 1) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_val("gap_busy", busy, 1);
    @(posedge clk);
    @(negedge clk);
    check_val("gap_end_idle", busy, 0);
  endtask

  initial begin
    int n_seen, acks, last_s, done_at, gg;
    bit pend, found;
    logic [3:0] exp_ack;

    // ---------------- reset values ----------------
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ctrl", {ack, err, tx_start, busy, active_id}, 0);
    check_val("rst_data", {tx_data, tx_len}, 0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    m_last = NREQ - 1;

    // ---------------- enable low blocks grants ----------------
    req = 4'hF; enable = 1'b0;
    n_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (tx_start || busy) n_seen++;
    end
    check_val("enable_low_idle", n_seen, 0);
    @(posedge clk); #1;
    req = '0;

    // ---------------- fairness with all requesting ----------------
    req_data = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
    req_len  = {6'd32, 6'd8, 6'd20, 6'd16};
    wait_idle();
    @(posedge clk); #1;
    enable = 1'b1; req = 4'hF;
    acks = 0; last_s = -1; pend = 0; done_at = 0; exp_ack = '0;
    for (int t = 0; t < 5 * (GAP_CYCLES + 20) + 50 && acks < 5; t++) begin
      @(posedge clk); #1;
      tx_done = pend && (cyc == done_at);
      if (tx_done) pend = 0;
      @(negedge clk);
      if (tx_start) begin
        gg = rr_pick(4'hF);
        m_last = gg;
        check_val("rr_grant", active_id, gg);
        check_val("rr_data", tx_data, req_data[32*gg +: 32]);
        if (last_s >= 0) check_val("rr_spacing", cyc - last_s, GAP_CYCLES + 6);
        pend = 1; done_at = cyc + 3; last_s = cyc;
        exp_ack = 4'(1 << gg);
      end
      if (ack != 0) begin
        check_val("rr_ack", ack, exp_ack);
        acks++;
      end
    end
    check_val("rr_ack_total", acks, 5);
    @(posedge clk); #1;
    req = '0; tx_done = 1'b0;

    // ---------------- basic word ----------------
    req_data[31:0] = 32'hA5A5_1234;
    req_len[5:0]   = 6'd16;
    do_word(4'b0001, 0, 20);

    // ---------------- bad lengths ----------------
    req_len[6*2 +: 6] = 6'd5;
    do_word(4'b0100, 0, 5);
    req_len[6*2 +: 6] = 6'd33;
    do_word(4'b0100, 0, 5);

    // ---------------- timeout and its boundary ----------------
    req_data[31:0] = 32'hDEAD_BEEF; req_len[5:0] = 6'd12;
    do_word(4'b0001, 0, -1);
    req_data[31:0] = 32'h0BAD_F00D; req_len[5:0] = 6'd32;
    do_word(4'b0001, 0, TIMEOUT - 1);

    // ---------------- transmitter busy at grant ----------------
    req_data[127:96] = 32'hCAFE_0008; req_len[23:18] = 6'd8;
    do_word(4'b1000, 10, 7);

    // ---------------- reset during WAIT ----------------
    req_data[63:32] = 32'h1357_9BDF; req_len[11:6] = 6'd24;
    wait_idle();
    @(posedge clk); #1;
    enable = 1'b1; req = 4'b0010;
    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      @(negedge clk);
      if (tx_start) found = 1;
      @(posedge clk); #1;
    end
    check_val("rst_mid_started", found, 1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0; req = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_mid_ctrl", {ack, err, tx_start, busy, active_id}, 0);
    check_val("rst_mid_data", {tx_data, tx_len}, 0);
    m_last = NREQ - 1;
    n_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack != 0 || err != 0 || tx_start) n_seen++;
    end
    check_val("rst_mid_no_pulse", n_seen, 0);
    req_len = {6'd9, 6'd10, 6'd11, 6'd12};
    do_word(4'b1111, 0, 5);

    // ---------------- randomized words ----------------
    for (int it = 0; it < 30; it++) begin
      int b, d;
      logic [3:0] m;
      req_data = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 9) < 8)      req_len[6*i +: 6] = 6'($urandom_range(8, 32));
        else if ($urandom_range(0, 1) == 0) req_len[6*i +: 6] = 6'($urandom_range(0, 7));
        else                                req_len[6*i +: 6] = 6'($urandom_range(33, 63));
      end
      m = 4'($urandom_range(1, 15));
      b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 12)) : 0;
      d = int'($urandom_range(1, 40));
      do_word(m, b, d);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
